// File: rtl/fadd_seq_ctrl_if.sv
// fadd_seq_ctrl_if: operand/result handshake bundle for the FP add sequencer.
//
// Handshake rules (both channels): a transfer happens on a rising clock edge
// where valid && ready are both high. A source holding valid keeps its payload
// stable until that edge. The sequencer's ready on the input side depends only
// on its own state, never on in_valid. The sequencer's out_valid is also
// state-only, and result/flags do not change while it waits for out_ready.
`timescale 1ns/1ps
interface fadd_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;
  logic        busy;

  // Producer/consumer side (testbench or upstream logic).
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags, busy
  );

  // Sequencer side.
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags, busy
  );
endinterface

// File: rtl/fadd_seq_ctrl.sv
// fadd_seq_ctrl: multi-cycle IEEE-754 single-precision add/subtract sequencer.
// Phases per operation: ALIGN -> ADD -> NORM (1..MAX_NORM cycles) -> ROUND -> OUT.
// Denormal inputs are flushed to zero; rounding is half-up on the guard bit.
// Optional build macro FADD_SEQ_FASTNORM_EN: NORM finishes in one cycle with a
// leading-zero count and one barrel shift instead of one bit per cycle.
// dbg_state mirrors the FSM state register for observation.
`timescale 1ns/1ps
module fadd_seq_ctrl #(
  parameter int MAX_NORM = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fadd_seq_ctrl_if.slave        bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  localparam int CW = $clog2(MAX_NORM + 1);

  // Architectural state.
  state_t      state_q,  state_d;
  logic [31:0] a_q,      a_d;
  logic [31:0] b_q,      b_d;
  logic        op_q,     op_d;
  logic [31:0] mant_l_q, mant_l_d;   // larger operand mantissa
  logic [31:0] mant_s_q, mant_s_d;   // smaller operand mantissa, aligned
  logic [9:0]  exp_q,    exp_d;      // working exponent, wide enough for +1 overflow
  logic        sign_q,   sign_d;
  logic        sub_q,    sub_d;      // effective subtraction
  logic [32:0] sum_q,    sum_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  flags_q,  flags_d;    // {invalid, overflow, underflow}
`ifndef FADD_SEQ_FASTNORM_EN
  logic [CW-1:0] cnt_q,  cnt_d;      // left-shift iterations taken in NORM
  logic [CW-1:0] cnt_inc;
`endif

  // Alignment helpers, derived from the captured operands.
  logic [7:0]  exp_a, exp_b, exp_big, exp_sml, exp_diff;
  logic [22:0] frac_a, frac_b;
  logic [31:0] man_a, man_b, man_big, man_sml;
  logic [4:0]  shamt;
  logic        a_ge_b, sign_b_eff, is_special;

  // Rounding helpers.
  logic [23:0] frac_rnd;
  logic [9:0]  exp_rnd;

`ifdef FADD_SEQ_FASTNORM_EN
  logic [5:0]  lz;
`endif

  // Operand unpack, magnitude compare and alignment shift for the ALIGN phase.
  always_comb begin
    exp_a      = a_q[30:23];
    exp_b      = b_q[30:23];
    frac_a     = a_q[22:0];
    frac_b     = b_q[22:0];
    // exp == 0 means zero or denormal; both are treated as zero.
    man_a      = (exp_a == 8'h00) ? 32'h0 : {1'b1, frac_a, 8'h00};
    man_b      = (exp_b == 8'h00) ? 32'h0 : {1'b1, frac_b, 8'h00};
    is_special = (exp_a == 8'hFF) || (exp_b == 8'hFF);
    // Exponent-then-fraction order is exactly the unsigned order of bits 30:0.
    a_ge_b     = (a_q[30:0] >= b_q[30:0]);
    sign_b_eff = b_q[31] ^ op_q;
    exp_big    = a_ge_b ? exp_a : exp_b;
    exp_sml    = a_ge_b ? exp_b : exp_a;
    man_big    = a_ge_b ? man_a : man_b;
    man_sml    = a_ge_b ? man_b : man_a;
    exp_diff   = exp_big - exp_sml;
    shamt      = (exp_diff > 8'd31) ? 5'd31 : exp_diff[4:0];
  end

  // Half-up rounding on the guard bit, with carry into the exponent.
  always_comb begin
    frac_rnd = {1'b0, sum_q[30:8]} + {23'h0, sum_q[7]};
    exp_rnd  = exp_q + {9'h0, frac_rnd[23]};
  end

`ifdef FADD_SEQ_FASTNORM_EN
  // Leading-zero count of the low 32 sum bits; highest set bit wins.
  always_comb begin
    lz = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (sum_q[i]) lz = 6'(31 - i);
    end
  end
`else
  assign cnt_inc = cnt_q + CW'(1);
`endif

  // Next-state and datapath updates for every phase.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    mant_l_d = mant_l_q;
    mant_s_d = mant_s_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    sub_d    = sub_q;
    sum_d    = sum_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifndef FADD_SEQ_FASTNORM_EN
    cnt_d    = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          op_d     = bus.op;
          result_d = 32'h0;
          flags_d  = 3'b000;
          state_d  = S_ALIGN;
        end
      end

      S_ALIGN: begin
        if (is_special) begin
          // Any Inf/NaN operand yields the canonical quiet NaN.
          result_d = 32'h7FC0_0000;
          flags_d  = 3'b100;
          state_d  = S_OUT;
        end else begin
          mant_l_d = man_big;
          mant_s_d = man_sml >> shamt;
          exp_d    = {2'b00, exp_big};
          sign_d   = a_ge_b ? a_q[31] : sign_b_eff;
          sub_d    = a_q[31] ^ sign_b_eff;
`ifndef FADD_SEQ_FASTNORM_EN
          cnt_d    = '0;
`endif
          state_d  = S_ADD;
        end
      end

      S_ADD: begin
        // The larger magnitude is always first, so subtraction never goes negative.
        if (sub_q) sum_d = {1'b0, mant_l_q} - {1'b0, mant_s_q};
        else       sum_d = {1'b0, mant_l_q} + {1'b0, mant_s_q};
        state_d = S_NORM;
      end

      S_NORM: begin
        if (sum_q == 33'h0) begin
          result_d = 32'h0;
          state_d  = S_OUT;
        end else if (sum_q[32]) begin
          sum_d   = sum_q >> 1;
          exp_d   = exp_q + 10'd1;
          state_d = S_ROUND;
        end else if (sum_q[31]) begin
          state_d = S_ROUND;
        end else begin
`ifdef FADD_SEQ_FASTNORM_EN
          // Same outcome as stepping one bit at a time: exponent hitting zero
          // first gives signed zero, hitting the iteration cap gives +0.
          if ((exp_q <= {4'h0, lz}) && (int'(exp_q) <= MAX_NORM)) begin
            result_d = {sign_q, 31'h0};
            flags_d  = 3'b001;
            state_d  = S_OUT;
          end else if (int'(lz) >= MAX_NORM) begin
            result_d = 32'h0;
            flags_d  = 3'b001;
            state_d  = S_OUT;
          end else begin
            sum_d   = sum_q << lz;
            exp_d   = exp_q - {4'h0, lz};
            state_d = S_ROUND;
          end
`else
          sum_d = sum_q << 1;
          exp_d = exp_q - 10'd1;
          cnt_d = cnt_inc;
          if (exp_q == 10'd1) begin
            result_d = {sign_q, 31'h0};
            flags_d  = 3'b001;
            state_d  = S_OUT;
          end else if (cnt_inc == CW'(MAX_NORM)) begin
            result_d = 32'h0;
            flags_d  = 3'b001;
            state_d  = S_OUT;
          end
`endif
        end
      end

      S_ROUND: begin
        if (exp_rnd >= 10'h0FF) begin
          result_d = {sign_q, 8'hFF, 23'h0};
          flags_d  = 3'b010;
        end else begin
          // On a rounding carry frac_rnd[22:0] is already zero.
          result_d = {sign_q, exp_rnd[7:0], frac_rnd[22:0]};
        end
        state_d = S_OUT;
      end

      S_OUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      op_q     <= 1'b0;
      mant_l_q <= 32'h0;
      mant_s_q <= 32'h0;
      exp_q    <= 10'h0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      sum_q    <= 33'h0;
      result_q <= 32'h0;
      flags_q  <= 3'b000;
`ifndef FADD_SEQ_FASTNORM_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      mant_l_q <= mant_l_d;
      mant_s_q <= mant_s_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      sub_q    <= sub_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      flags_q  <= flags_d;
`ifndef FADD_SEQ_FASTNORM_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/fadd_seq_ctrl.md
# fadd_seq_ctrl

Multi-cycle sequencer for IEEE-754 single-precision add/subtract. Accepts one operand pair per transaction over a valid/ready handshake. Then steps through four phases: unpack/align, mantissa add/subtract, normalize, round. Returns the packed result with status flags over a second valid/ready handshake, and occupies the FP adder datapath one operation at a time.

## Interface
- `MAX_NORM`, 24: normalize-loop iteration cap; reaching it forces the result to zero.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  controller idle, can accept.
- `a`, `b`  in  32  IEEE-754 single operands.
- `op`  in  1  0 = a+b, 1 = a−b.
- `out_valid`  out  1  result valid, held until taken.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  32  packed IEEE-754 result.
- `flags`  out  3  {invalid, overflow, underflow}.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ALIGN, ADD, NORM, ROUND, OUT.
- **IDLE**
  - `in_ready`=1.
  - When `in_valid`&&`in_ready`, register a, b, op; go to ALIGN.
- **ALIGN**
  - Inputs with exp=0 are treated as zero (denormals flushed).
  - If either exp=0xFF: result=0x7FC00000, invalid=1, go to OUT.
  - Build 32-bit mantissas {1'b1, frac[22:0], 8'b0}.
  - Larger operand is chosen by exponent, then fraction on a tie.
  - Shift the smaller operand right by min(exp difference, 31).
  - Effective subtract = sign_a ^ sign_b ^ op.
  - Result sign = sign of the larger operand, with b's sign inverted when op=1.
- **ADD**
  - 33-bit sum: larger+smaller, or larger−smaller.
  - Register the sum and the larger exponent.
- **NORM**, one step per cycle:
  - Sum zero: result=+0x00000000, go to OUT.
  - Bit 32 set: shift right 1, exp+1, go to ROUND.
  - Bit 31 set: go to ROUND.
  - Otherwise shift left 1, exp−1, and stay in NORM.
  - exp reaching 0: result=signed zero, underflow=1, go to OUT.
  - Iteration count reaching MAX_NORM: result=+0, underflow=1, go to OUT.
- **ROUND**
  - Round half-up on guard bit [7]: frac=sum[30:8]+sum[7].
  - Carry out of frac sets frac=0 and exp+1.
  - exp ≥ 0xFF: result=signed infinity (0x7F800000 | sign<<31), overflow=1.
  - Go to OUT.
- **OUT**
  - `out_valid`=1; `result` and `flags` stable.
  - On `out_ready`, clear `out_valid` and return to IDLE.
- `flags` are cleared on each new accept.

## Timing
- Reset (async assert, sync release): state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0, `flags`=0.
- Reset mid-operation aborts the transaction; nothing is output.
- Accept at edge N → ALIGN N+1, ADD N+2, NORM N+3…N+2+k, ROUND, `out_valid` high.
  - Minimum latency: 5 cycles from accept to `out_valid` (k=1).
  - Invalid-input latency: 2 cycles.
- `in_ready` is low from the cycle after accept until the cycle after the OUT handshake.
- Back-to-back throughput: one transaction per (latency+1) cycles when `out_ready` is held high.
- `out_valid` with `out_ready`=0 holds indefinitely with all outputs unchanged.
- `in_valid` is ignored while busy; the producer must hold it.

## Configuration
- `FADD_SEQ_FASTNORM_EN` defined:
  - NORM completes in exactly one cycle using a leading-zero count and a single barrel shift.
  - Same underflow rules as the iterative path.
  - Minimum latency 5 cycles; worst case also 5.
- Undefined:
  - Iterative one-bit-per-cycle normalize as described in Operation.
  - Worst case k=MAX_NORM.

## Test plan
- 0x3F800000 + 0x3F800000, op=0 → result 0x40000000, flags 0, `out_valid` 5 cycles after accept.
- 0x3F800000 − 0x3F400000 → 0x3E800000.
  - Without the macro: NORM takes 3 cycles, latency 7.
  - With the macro: latency 5.
- 0x3F800000 − 0x3F800000 → 0x00000000, flags 0.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1.
- a=0x7F800000 with any b → 0x7FC00000, invalid=1, latency 2.
- Hold `out_ready`=0 for 10 cycles → `out_valid` and `result` remain stable and `in_ready`=0.
- Assert `rst_n` low during NORM → all outputs return to reset values immediately.
- After release, a new accept completes normally.
